// File: rtl/unidad_busqueda_pkg.sv
// Shared types and constants for the instruction fetch unit.
package paquete_cpu;

  localparam int ANCHO_INST = 32;
  localparam logic [31:0] INC_PC = 32'd4;

  // Fetch controller states: BUSCAR fetches, ERROR halts fetching until reset.
  typedef enum logic {
    BUSCAR = 1'b0,
    ERROR  = 1'b1
  } estado_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]           pc;
    logic [ANCHO_INST-1:0] inst;
  } entrada_t;

endpackage

// File: rtl/unidad_busqueda_if.sv
// Fetch unit bus: instruction-memory read port, redirect input and decode handshake.
interface unidad_busqueda_if;
  import paquete_cpu::*;

  logic [31:0]           Dir;
  logic [ANCHO_INST-1:0] Inst;
  logic                  salto_valido;
  logic [31:0]           salto_dir;
  logic                  inst_valida;
  logic [ANCHO_INST-1:0] inst_out;
  logic [31:0]           pc_out;
  logic                  dec_listo;
  logic                  error_dir;
  logic [31:0]           contador_inst;

  // Fetch unit side.
  modport master (
    output Dir, inst_valida, inst_out, pc_out, error_dir, contador_inst,
    input  Inst, salto_valido, salto_dir, dec_listo
  );

  // Memory / execute / decode side.
  modport slave (
    input  Dir, inst_valida, inst_out, pc_out, error_dir, contador_inst,
    output Inst, salto_valido, salto_dir, dec_listo
  );

endinterface

// File: rtl/unidad_busqueda_fifo.sv
// fifo_busqueda: 2-entry synchronous FIFO of {pc, inst}. Flush beats push and pop.
module fifo_busqueda
  import paquete_cpu::*;
#(
  parameter int PROF = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  entrada_t dato_in,
  output entrada_t dato_out,
  output logic     lleno,
  output logic     vacio
);

  entrada_t    mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  cuenta;

  // Storage, pointers and occupancy; a push into a full buffer is only issued alongside a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset too so the head presents zeros (inst_out/pc_out) after reset.
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cuenta <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cuenta <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dato_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   cuenta <= cuenta + 2'd1;
        2'b01:   cuenta <= cuenta - 2'd1;
        default: cuenta <= cuenta;
      endcase
    end
  end

  assign dato_out = mem[rd_ptr];
  assign lleno    = (cuenta == 2'(PROF));
  assign vacio    = (cuenta == 2'd0);

endmodule

// File: rtl/unidad_busqueda.sv
// unidad_busqueda: instruction fetch unit. Drives Dir=PC, captures Inst in the same cycle
// and queues {pc, inst} for decode. Redirects flush the queue; illegal addresses halt fetch.
// Optional delivered-instruction counter enabled by UNIDAD_BUSQUEDA_CONTADOR_EN.
module unidad_busqueda
  import paquete_cpu::*;
#(
  parameter logic [31:0] DIR_RESET = 32'h0,
  parameter int unsigned MEM_BYTES = 1000,
  parameter int          PROF_FIFO = 2
) (
  input logic                clk,
  input logic                rst_n,
  unidad_busqueda_if.master  bus
);

  localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

  estado_t     estado_q, estado_d;
  logic [31:0] pc_q, pc_d;
  logic        error_q, error_d;
  logic        push, pop, flush;
  logic        lleno, vacio;
  entrada_t    cabeza;

  // State, PC and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= BUSCAR;
      pc_q     <= DIR_RESET;
      error_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      estado_q <= estado_d;
      pc_q     <= pc_d;
      error_q  <= error_d;
    end
  end

  // Next state, next PC and FIFO control; redirect overrides push and pop.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    estado_d = estado_q;
    pc_d     = pc_q;
    error_d  = error_q;
    push     = 1'b0;
    flush    = 1'b0;
    pop      = !vacio && bus.dec_listo;
    if (estado_q == BUSCAR) begin
      if (bus.salto_valido) begin
        flush = 1'b1;
        pop   = 1'b0;
        if (bus.salto_dir[1:0] == 2'b00 && bus.salto_dir <= PC_MAX) begin
          pc_d = bus.salto_dir;
        end else begin
          error_d  = 1'b1;
          estado_d = ERROR;
        end
      end else if (pc_q > PC_MAX) begin
        error_d  = 1'b1;
        estado_d = ERROR;
      end else if (!lleno || pop) begin
        push = 1'b1;
        pc_d = pc_q + INC_PC;
      end
    end
  end

  fifo_busqueda #(.PROF(PROF_FIFO)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .dato_in  ('{pc: pc_q, inst: bus.Inst}),
    .dato_out (cabeza),
    .lleno    (lleno),
    .vacio    (vacio)
  );

  assign bus.Dir         = pc_q;
  assign bus.inst_valida = !vacio;
  assign bus.inst_out    = cabeza.inst;
  assign bus.pc_out      = cabeza.pc;
  assign bus.error_dir   = error_q;

`ifdef UNIDAD_BUSQUEDA_CONTADOR_EN
  logic [31:0] contador_q;

  // Delivered-instruction counter, wraps modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      contador_q <= 32'd0;
    end else if (pop) begin
      contador_q <= contador_q + 32'd1;
    end
  end

  assign bus.contador_inst = contador_q;
`else
  assign bus.contador_inst = 32'd0;
`endif

endmodule
